// File: rtl/knn_topk_list.sv
// knn_topk_list: keeps the K nearest candidates of a query as a sorted list.
// Candidates arrive one per cycle and are inserted into a shift-register list
// ordered by distance. Equal distances keep arrival order.
// Optional macro KNN_VOTE_EN adds a VOTE state that scans the final list for
// the most frequent label and drives vote_label.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FILL  | query open, accepting candidates
// VOTE  | majority-label scan, one list index per cycle (KNN_VOTE_EN)
// DONE  | result stable until the next start
module knn_topk_list #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K       = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [DATA_W-1:0]        in_dist,
    input  logic [LABEL_W-1:0]       in_label,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(K+1)-1:0]   count,
    output logic [DATA_W*K-1:0]      dist_out,
    output logic [LABEL_W*K-1:0]     label_out
`ifdef KNN_VOTE_EN
    ,
    output logic [LABEL_W-1:0]       vote_label
`endif
);

    localparam int CW = $clog2(K+1);
    localparam int IW = $clog2(K);

`ifdef KNN_VOTE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2, S_VOTE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_W-1:0]    dist_q  [K];
    logic [DATA_W-1:0]    dist_d  [K];
    logic [LABEL_W-1:0]   label_q [K];
    logic [LABEL_W-1:0]   label_d [K];
    logic                 arm_q, arm_d;
    logic                 start_eff;
    logic [CW-1:0]        ins_pos;
    logic                 do_clear;
    logic                 do_insert;

`ifdef KNN_VOTE_EN
    logic [IW-1:0]        scan_q, scan_d;
    logic [CW-1:0]        best_cnt_q, best_cnt_d;
    logic [LABEL_W-1:0]   best_lab_q, best_lab_d;
    logic [LABEL_W-1:0]   vote_q, vote_d;
    logic [LABEL_W-1:0]   cand_lab;
    logic [CW-1:0]        occ;
    logic [LABEL_W-1:0]   new_lab;
    logic [CW-1:0]        new_cnt;
`endif

    // Reset release is retimed through arm_q; start is masked on the first
    // edge after deassertion and honoured from the second edge onward.
    always_comb arm_d = 1'b1;

    // Reset-release synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) arm_q <= 1'b0;
        else      arm_q <= arm_d;
    end

    assign start_eff = start & arm_q;

    // Insert position: number of valid entries with dist <= in_dist.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if ((CW'(i) < count_q) && (dist_q[i] <= in_dist)) ins_pos = ins_pos + CW'(1);
        end
    end

`ifdef KNN_VOTE_EN
    // Occurrences of the label under the scan pointer, and the running best.
    always_comb begin
        cand_lab = label_q[scan_q];
        occ      = '0;
        for (int j = 0; j < K; j++) begin
            if ((CW'(j) < count_q) && (label_q[j] == cand_lab)) occ = occ + CW'(1);
        end
        new_lab = best_lab_q;
        new_cnt = best_cnt_q;
        if (occ > best_cnt_q) begin
            new_lab = cand_lab;
            new_cnt = occ;
        end
    end
`endif

    // Next-state, list insertion and clear.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        do_clear  = 1'b0;
        do_insert = 1'b0;
        for (int i = 0; i < K; i++) begin
            dist_d[i]  = dist_q[i];
            label_d[i] = label_q[i];
        end
`ifdef KNN_VOTE_EN
        scan_d     = scan_q;
        best_cnt_d = best_cnt_q;
        best_lab_d = best_lab_q;
        vote_d     = vote_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_eff) do_clear = 1'b1;
            end
            S_FILL: begin
                if (start_eff) begin
                    do_clear = 1'b1;
                end else if (in_valid) begin
                    do_insert = 1'b1;
                    if (in_last) begin
`ifdef KNN_VOTE_EN
                        state_d    = S_VOTE;
                        scan_d     = '0;
                        best_cnt_d = '0;
                        best_lab_d = '0;
`else
                        state_d    = S_DONE;
`endif
                    end
                end
            end
`ifdef KNN_VOTE_EN
            S_VOTE: begin
                if (start_eff) begin
                    do_clear = 1'b1;
                end else if (count_q == '0) begin
                    vote_d  = '0;
                    state_d = S_DONE;
                end else begin
                    best_lab_d = new_lab;
                    best_cnt_d = new_cnt;
                    if (CW'(scan_q) == count_q - CW'(1)) begin
                        vote_d  = new_lab;
                        state_d = S_DONE;
                    end else begin
                        scan_d = scan_q + IW'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (do_insert && (ins_pos != CW'(K))) begin
            for (int i = 0; i < K; i++) begin
                if (CW'(i) > ins_pos) begin
                    dist_d[i]  = dist_q[(i > 0) ? i - 1 : 0];
                    label_d[i] = label_q[(i > 0) ? i - 1 : 0];
                end else if (CW'(i) == ins_pos) begin
                    dist_d[i]  = in_dist;
                    label_d[i] = in_label;
                end
            end
            count_d = (count_q == CW'(K)) ? count_q : count_q + CW'(1);
        end

        if (do_clear) begin
            state_d = S_FILL;
            count_d = '0;
            for (int i = 0; i < K; i++) begin
                dist_d[i]  = '1;
                label_d[i] = '0;
            end
`ifdef KNN_VOTE_EN
            vote_d     = '0;
            scan_d     = '0;
            best_cnt_d = '0;
            best_lab_d = '0;
`endif
        end
    end

    // State and list registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= '1;
                label_q[i] <= '0;
            end
`ifdef KNN_VOTE_EN
            scan_q     <= '0;
            best_cnt_q <= '0;
            best_lab_q <= '0;
            vote_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= dist_d[i];
                label_q[i] <= label_d[i];
            end
`ifdef KNN_VOTE_EN
            scan_q     <= scan_d;
            best_cnt_q <= best_cnt_d;
            best_lab_q <= best_lab_d;
            vote_q     <= vote_d;
`endif
        end
    end

    // Output packing and status decode.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            dist_out[i*DATA_W +: DATA_W]    = dist_q[i];
            label_out[i*LABEL_W +: LABEL_W] = label_q[i];
        end
        count    = count_q;
        in_ready = (state_q == S_FILL) && !start_eff;
`ifdef KNN_VOTE_EN
        busy       = (state_q == S_FILL) || (state_q == S_VOTE);
        vote_label = vote_q;
`else
        busy       = (state_q == S_FILL);
`endif
        done = (state_q == S_DONE);
    end

endmodule

// File: doc/knn_topk_list.md
KNN_TOPK_LIST -- requirements
Module: knn_topk_list

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, distance width (unsigned); LABEL_W, default 8, label width; K, default 10, list depth (2..32).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous assert, active-low
- start  in  1  clear list and open a new query
- in_valid  in  1  candidate present
- in_ready  out  1  candidate accepted when in_valid & in_ready
- in_last  in  1  final candidate of query, qualified by in_valid & in_ready
- in_dist  in  DATA_W  candidate distance
- in_label  in  LABEL_W  candidate label
- busy  out  1  query in progress
- done  out  1  result stable
- count  out  $clog2(K+1)  number of valid entries
- dist_out  out  DATA_W*K  sorted distances; entry 0 in LSBs, entry 0 nearest
- label_out  out  LABEL_W*K  labels matching dist_out
- vote_label  out  LABEL_W  majority label (KNN_VOTE_EN only)

Function
REQ-003 The block SHALL implement FSM states IDLE, FILL, VOTE, DONE.
REQ-004 IDLE, DONE: start SHALL go to FILL next cycle, set count=0, set all dist entries to all-ones and all label entries to 0.
REQ-005 start in FILL or VOTE SHALL abort the query and restart identically to REQ-004.
REQ-006 in_ready SHALL be 1 only in FILL with start low; start takes priority, and a candidate presented with start is dropped.
REQ-007 in_valid outside FILL SHALL be ignored, with no state change.
REQ-008 An accepted candidate SHALL be inserted at position p = number of entries with index < count and dist <= in_dist (unsigned compare).
- Ties place the new entry after existing equal entries.
REQ-009 If p < K, entries p..K-2 SHALL shift to p+1..K-1, the old entry K-1 is discarded, and the candidate is written at p.
- If p == K, the candidate SHALL be discarded.
REQ-010 count SHALL increment on each inserted candidate and saturate at K.
REQ-011 List updates SHALL be visible on outputs the cycle after acceptance, with throughput of one candidate per cycle and no bubbles.
REQ-012 An accepted beat with in_last=1 SHALL be processed normally, then move FILL to VOTE (macro defined) or DONE (macro undefined).
REQ-013 busy SHALL be 1 in FILL and VOTE; done SHALL be 1 in DONE only, held until next start.
REQ-014 dist_out, label_out and count SHALL hold stable in DONE.

Reset
REQ-015 rst low SHALL asynchronously force:
- state IDLE; count=0
- dist entries all-ones; label entries 0
- in_ready=0, busy=0, done=0, vote_label=0
REQ-016 Reset deassertion SHALL be synchronised internally, and the block SHALL accept start on the second rising edge after deassertion.
REQ-017 Reset mid-query SHALL discard all list contents.

Configuration
REQ-018 Macro KNN_VOTE_EN SHALL compile in the VOTE state and the vote_label port.
REQ-019 With KNN_VOTE_EN, VOTE SHALL scan index i = 0..count-1, one index per cycle.
- Occurrences of label[i] among the first count entries are counted.
- The running best SHALL be replaced only on strictly greater occurrences, so ties resolve to the nearest entry.
REQ-020 With KNN_VOTE_EN, VOTE SHALL last max(count,1) cycles and then enter DONE with vote_label valid.
- count == 0 yields vote_label 0.
REQ-021 Without KNN_VOTE_EN, vote_label and the VOTE state SHALL not exist, and done SHALL assert the cycle after the in_last beat.

Verification (K=4, DATA_W=8, LABEL_W=4)
REQ-022 Reset, start, then dists 9,3,7,5 (labels 1,2,3,4), last on 5:
- required: dist_out 3,5,7,9; labels 2,4,3,1; count 4.
REQ-023 Full list 3,5,7,9, then dists 4 and 20 (last):
- required: 4 evicts 9, giving 3,4,5,7.
- required: 20 discarded; count stays 4.
REQ-024 Ties: dists 5 (label A), 5 (label B), 5 (label C):
- required: order A,B,C; count 3.
REQ-025 start asserted with in_valid high mid-FILL:
- required: candidate dropped, in_ready=0 that cycle, list cleared, count 0 next cycle.
REQ-026 KNN_VOTE_EN, labels 2,4,2,4 at dists 1,2,3,4:
- required: vote_label 2 (tie resolved to nearest).
- required: done asserts 4 cycles after entering VOTE.
REQ-027 rst pulsed low in VOTE:
- required: immediate IDLE, all outputs at reset values.
